instr_fetch_reader: RTL and testbench

- Consumer side of the program-counter address stream.
- Takes the byte address presented by the program counter and reads one instruction of INSTR_BYTES bytes, one byte per transfer, over a req/ack byte-memory port.
- Assembles the bytes little-endian and presents the word to the decoder with a valid/ready handshake.
- Pulses pc_advance so the counter steps by INSTR_BYTES once the word is accepted.

---
 rtl/instr_fetch_reader_if.sv | 29 ++
 rtl/instr_fetch_reader.sv | 125 ++++++++++++
 tb/tb_instr_fetch_reader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_reader_if.sv
// Fetch-side bundle: PC address stream, byte-memory req/ack port and decoder handshake.
// master = the fetch reader, slave = its surroundings (PC, memory, decoder).
interface instr_fetch_reader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_valid;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              pc_advance;
  logic              fetch_err;
  logic              busy;

  modport master (
    input  pc_addr, pc_valid, flush, mem_ack, mem_data, instr_ready,
    output mem_req, mem_addr, instr, instr_valid, pc_advance, fetch_err, busy
  );

  modport slave (
    output pc_addr, pc_valid, flush, mem_ack, mem_data, instr_ready,
    input  mem_req, mem_addr, instr, instr_valid, pc_advance, fetch_err, busy
  );
endinterface

// File: rtl/instr_fetch_reader.sv
// Reads one little-endian instruction byte-by-byte from the PC address, hands it to the
// decoder with valid/ready, and pulses pc_advance when the word is accepted.
module instr_fetch_reader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_fetch_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StErr} state_e;

  localparam logic [1:0] LastK   = 2'(INSTR_BYTES - 1);
  localparam logic [7:0] WaitMax = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        k_q, k_d;
  logic [7:0]        wait_q, wait_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, instr_valid_q, pc_advance_q, fetch_err_q, busy_q;
  logic              pc_advance_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      base_q        <= '0;
      k_q           <= '0;
      wait_q        <= '0;
      instr_q       <= '0;
      mem_addr_q    <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_advance_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      k_q           <= k_d;
      wait_q        <= wait_d;
      instr_q       <= instr_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= (state_d == StFetch);
      instr_valid_q <= (state_d == StHold);
      pc_advance_q  <= pc_advance_d;
      fetch_err_q   <= (state_d == StErr);
      busy_q        <= (state_d != StIdle);
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    k_d          = k_q;
    wait_d       = wait_q;
    instr_d      = instr_q;
    pc_advance_d = 1'b0;

    if (bus.flush) begin
      // Redirect: drop any in-flight byte or held word without advancing the PC.
      state_d = StIdle;
      k_d     = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.pc_valid) begin
            base_d  = bus.pc_addr;
            instr_d = '0;
            k_d     = '0;
            wait_d  = '0;
            state_d = StFetch;
          end
        end
        StFetch: begin
          // An ack in the same cycle the wait count hits the limit still counts.
          if (bus.mem_ack) begin
            instr_d[{k_q, 3'b000} +: 8] = bus.mem_data;
            wait_d = '0;
            if (k_q == LastK) begin
              state_d = StHold;
            end else begin
              k_d = k_q + 2'd1;
            end
          end else if (wait_q == WaitMax) begin
            state_d = StErr;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        StHold: begin
          if (bus.instr_ready) begin
            state_d      = StIdle;
            pc_advance_d = 1'b1;
          end
        end
        StErr: begin
          state_d = StErr;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Address stays put outside FETCH so the bus is quiet while holding or idle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (state_d == StFetch) begin
      mem_addr_d = base_d + ADDR_W'(k_d);
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc_advance  = pc_advance_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch_reader.sv
// Directed and randomized bench for instr_fetch_reader against a byte-array memory model.
module tb_instr_fetch_reader;
  localparam int unsigned NB      = 4;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_reader_if #(.ADDR_W(8)) bus ();

  instr_fetch_reader #(
    .ADDR_W     (8),
    .INSTR_BYTES(NB),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] mem [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected word: bytes at consecutive wrapping addresses, little-endian.
  function automatic logic [31:0] model_word(input logic [7:0] base);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < NB; k++) w = w | (32'(mem[8'(base + k)]) << (8 * k));
    return w;
  endfunction

  task automatic do_fetch(input logic [7:0] base, input int dly, input int rdy_wait,
                          input bit finish);
    logic [31:0] exp_w;
    logic [7:0]  addr;
    int          cyc;
    exp_w = model_word(base);
    bus.pc_addr  = base;
    bus.pc_valid = 1'b1;
    tick;
    bus.pc_valid = 1'b0;
    cyc = 1;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_instr_clr", bus.instr, 32'd0);
    for (int k = 0; k < NB; k++) begin
      addr = 8'(base + k);
      for (int d = 0; d < dly; d++) begin
        bus.mem_ack = 1'b0;
        check("stall_req", 32'(bus.mem_req), 32'd1);
        check("stall_addr", 32'(bus.mem_addr), 32'(addr));
        tick;
        cyc++;
      end
      check("ack_addr", 32'(bus.mem_addr), 32'(addr));
      check("fetch_no_valid", 32'(bus.instr_valid), 32'd0);
      bus.mem_ack  = 1'b1;
      bus.mem_data = mem[addr];
      tick;
      cyc++;
      bus.mem_ack  = 1'b0;
      bus.mem_data = 8'($urandom);
    end
    check("hold_valid", 32'(bus.instr_valid), 32'd1);
    check("hold_word", bus.instr, exp_w);
    check("hold_req_low", 32'(bus.mem_req), 32'd0);
    check("latency", 32'(cyc), 32'(NB * (dly + 1) + 1));
    for (int i = 0; i < rdy_wait; i++) begin
      bus.instr_ready = 1'b0;
      bus.pc_valid    = 1'($urandom_range(0, 1));
      bus.pc_addr     = 8'($urandom);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_word", bus.instr, exp_w);
      check("bp_no_adv", 32'(bus.pc_advance), 32'd0);
      tick;
    end
    bus.pc_valid = 1'b0;
    if (!finish) return;
    bus.instr_ready = 1'b1;
    tick;
    bus.instr_ready = 1'b0;
    check("adv_pulse", 32'(bus.pc_advance), 32'd1);
    check("adv_valid_low", 32'(bus.instr_valid), 32'd0);
    check("adv_idle", 32'(bus.busy), 32'd0);
    check("adv_word_kept", bus.instr, exp_w);
    tick;
    check("adv_one_cycle", 32'(bus.pc_advance), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_adv"}, 32'(bus.pc_advance), 32'd0);
    check({tag, "_err"}, 32'(bus.fetch_err), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    bus.pc_addr     = '0;
    bus.pc_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_data    = '0;
    bus.instr_ready = 1'b0;
    tick;
    tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Basic fetch of a known word.
    mem[8'h10] = 8'h13;
    mem[8'h11] = 8'h05;
    mem[8'h12] = 8'h50;
    mem[8'h13] = 8'h00;
    do_fetch(8'h10, 0, 0, 1'b1);

    // Backpressure with pc_valid noise during HOLD.
    do_fetch(8'h20, 0, 6, 1'b1);

    // Address wrap with 3-cycle stalls per byte.
    do_fetch(8'hFE, 3, 2, 1'b1);

    // Ack on the very last permitted wait cycle.
    do_fetch(8'h40, TIMEOUT, 1, 1'b1);

    // Timeout: no ack at all.
    bus.pc_addr  = 8'h50;
    bus.pc_valid = 1'b1;
    tick;
    bus.pc_valid = 1'b0;
    for (int i = 0; i <= TIMEOUT; i++) begin
      check("to_req_wait", 32'(bus.mem_req), 32'd1);
      check("to_no_err", 32'(bus.fetch_err), 32'd0);
      tick;
    end
    check("to_req_drop", 32'(bus.mem_req), 32'd0);
    check("to_err", 32'(bus.fetch_err), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd1);
    bus.mem_ack  = 1'b1;
    bus.pc_valid = 1'b1;
    tick;
    tick;
    bus.mem_ack  = 1'b0;
    bus.pc_valid = 1'b0;
    check("err_sticky", 32'(bus.fetch_err), 32'd1);
    check("err_no_valid", 32'(bus.instr_valid), 32'd0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    check("flush_err_clr", 32'(bus.fetch_err), 32'd0);
    check("flush_err_idle", 32'(bus.busy), 32'd0);
    check("flush_err_req", 32'(bus.mem_req), 32'd0);
    do_fetch(8'h60, 1, 0, 1'b1);

    // Flush on the byte-2 ack.
    bus.pc_addr  = 8'h70;
    bus.pc_valid = 1'b1;
    tick;
    bus.pc_valid = 1'b0;
    bus.mem_ack  = 1'b1;
    tick;
    tick;
    bus.flush = 1'b1;
    tick;
    bus.flush   = 1'b0;
    bus.mem_ack = 1'b0;
    check("fl_req", 32'(bus.mem_req), 32'd0);
    check("fl_busy", 32'(bus.busy), 32'd0);
    check("fl_valid", 32'(bus.instr_valid), 32'd0);
    check("fl_adv", 32'(bus.pc_advance), 32'd0);
    tick;
    tick;
    check("fl_stays_idle", 32'(bus.busy), 32'd0);

    // Flush beats pc_valid in IDLE.
    bus.flush    = 1'b1;
    bus.pc_valid = 1'b1;
    tick;
    bus.flush    = 1'b0;
    bus.pc_valid = 1'b0;
    check("flpv_busy", 32'(bus.busy), 32'd0);
    check("flpv_req", 32'(bus.mem_req), 32'd0);

    // Flush together with the ready handshake.
    do_fetch(8'h80, 0, 1, 1'b0);
    bus.instr_ready = 1'b1;
    bus.flush       = 1'b1;
    tick;
    bus.instr_ready = 1'b0;
    bus.flush       = 1'b0;
    check("flrdy_adv", 32'(bus.pc_advance), 32'd0);
    check("flrdy_valid", 32'(bus.instr_valid), 32'd0);
    check("flrdy_busy", 32'(bus.busy), 32'd0);
    tick;
    check("flrdy_adv2", 32'(bus.pc_advance), 32'd0);

    // Randomized fetches.
    for (int n = 0; n < 20; n++) begin
      do_fetch(8'($urandom), int'($urandom_range(0, TIMEOUT)), int'($urandom_range(0, 4)),
               1'b1);
    end

    // Reset while holding a word.
    do_fetch(8'h90, 0, 2, 1'b0);
    rst_n = 1'b0;
    bus.instr_ready = 1'b1;
    tick;
    bus.instr_ready = 1'b0;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    tick;
    check("rst_no_adv", 32'(bus.pc_advance), 32'd0);
    check("rst_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
